// File: rtl/rng_xy.sv
// Uniform grid-coordinate generator: 16-bit Galois LFSR with rejection sampling per axis.
// Latency: 2 cycles best case from req sample to DONE (+1 per rejected candidate); req ignored while busy.
module rng_xy #(
    parameter int GRID_W = 20,
    parameter int GRID_H = 15,
    parameter int XW     = 5,
    parameter int YW     = 4
) (
    input  logic          CLK500Hz,
    input  logic          rst,
    input  logic [15:0]   seed,
    input  logic          load,
    input  logic          req,
    output logic          busy,
    output logic          valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW_X = 2'd1,
        DRAW_Y = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned GW = GRID_W;
    localparam int unsigned GH = GRID_H;

    state_t        state_q;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;
    logic [15:0]   seed_fix;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [31:0]   cand_x;
    logic [31:0]   cand_y;
    logic          x_ok;
    logic          y_ok;

    // A zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_fix = (seed == 16'h0000) ? 16'h0001 : seed;
    assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    assign cand_x = 32'(lfsr_q[XW-1:0]);
    assign cand_y = 32'(lfsr_q[YW-1:0]);
    assign x_ok   = cand_x < GW;
    assign y_ok   = cand_y < GH;

    always_ff @(posedge CLK500Hz) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= seed_fix;
            x_q     <= '0;
            y_q     <= '0;
        end else if (load) begin
            state_q <= IDLE;
            lfsr_q  <= seed_fix;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) state_q <= DRAW_X;
                end
                DRAW_X: begin
                    lfsr_q <= lfsr_d;
                    if (x_ok) begin
                        x_q     <= lfsr_q[XW-1:0];
                        state_q <= DRAW_Y;
                    end
                end
                DRAW_Y: begin
                    lfsr_q <= lfsr_d;
                    if (y_ok) begin
                        y_q     <= lfsr_q[YW-1:0];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign valid = (state_q == DONE);
    assign x     = x_q;
    assign y     = y_q;

endmodule
